gshare_bp: RTL and testbench
============================

Name: gshare_bp

Overview:
- Parametrised gshare conditional-branch predictor for the CVA6 frontend; successor to the fixed 2-bit global predictor.
- Table index = fetch PC XOR folded global history register (GHR). Counter width, history length and fetch width are parameters.
- Adds speculative GHR update at predict time and GHR repair on mispredict.
- Registered (SRAM-style) table read with same-cycle write bypass; flush is a multi-cycle table sweep FSM instead of a one-cycle clear.

Parameters:
- NR_ENTRIES, 1024: total counters; power of two.
- INSTR_PER_FETCH, 2: slots per row; power of two.
- CTR_BITS, 2: saturating counter width, >=2.
- GHR_BITS, 12: global history length, >=1.
- VLEN, 39: virtual PC width.
- RVC, 1: 1 gives OFFSET=1, 0 gives OFFSET=2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- flush_bp_i  in  1  start table sweep
- debug_mode_i  in  1  suppress table writes when high
- vpc_valid_i  in  1  lookup request
- vpc_i  in  VLEN  fetch PC
- spec_valid_i  in  1  frontend commits a predicted conditional branch this cycle
- spec_taken_i  in  1  its predicted direction
- upd_valid_i  in  1  resolved-branch update
- upd_pc_i  in  VLEN  resolved branch PC
- upd_taken_i  in  1  actual direction
- upd_mispredict_i  in  1  direction was mispredicted
- upd_ghr_i  in  GHR_BITS  GHR snapshot carried with the branch
- pred_valid_o  out  INSTR_PER_FETCH  per-slot entry valid
- pred_taken_o  out  INSTR_PER_FETCH  per-slot counter MSB
- pred_ghr_o  out  GHR_BITS  GHR used for this lookup
- ready_o  out  1  low during sweep

Behaviour:
- Derived widths:
  - NR_ROWS = NR_ENTRIES/INSTR_PER_FETCH
  - RB = clog2(NR_ROWS)
  - SB = clog2(INSTR_PER_FETCH)
- Slot = pc[OFFSET+SB-1:OFFSET]; zero when RVC=0.
- Row = pc[OFFSET+SB+RB-1:OFFSET+SB] XOR fold(ghr). fold XORs successive RB-bit chunks of ghr, with the top chunk zero-padded.
- Entry = {valid, ctr[CTR_BITS-1:0]}. Init value = valid 0, ctr = 1<<(CTR_BITS-1) (weakly taken).
- Lookup: issue in cycle N when vpc_valid_i && ready_o. pred_* registered and valid in N+1; they hold their last value otherwise.
- Lookup uses the current ghr_q before any same-cycle speculative shift. pred_ghr_o = that ghr_q.
- Update: row computed from upd_pc_i and upd_ghr_i.
  - Read-modify-write in one cycle: set valid=1; ctr+1 if taken, ctr-1 if not taken.
  - Counter saturates at all-ones and at zero, with no wrap.
  - Write is suppressed when debug_mode_i or !ready_o.
- Bypass: if the update writes the same row and slot a lookup reads in the same cycle, the lookup returns the post-update entry.
- GHR, priority highest first:
  - upd_valid_i && upd_mispredict_i: ghr_d = {upd_ghr_i[GHR_BITS-2:0], upd_taken_i}. A same-cycle spec_valid_i is dropped.
  - else spec_valid_i: ghr_d = {ghr_q[GHR_BITS-2:0], spec_taken_i}.
  - else hold.
  - GHR_BITS=1 degenerates to the single new bit.
  - Repair happens even in debug mode and during a sweep.
- FSM:
  - SWEEP: write the init value to row cnt (all slots); cnt++ each cycle. When cnt==NR_ROWS-1, go to IDLE.
  - IDLE: flush_bp_i loads cnt=0 and goes to SWEEP.
  - flush_bp_i while in SWEEP restarts cnt at 0.
- While in SWEEP: ready_o=0, lookups ignored, pred_valid_o=0 the following cycle, updates dropped.
- Reset, asynchronous and possibly mid-operation:
  - state=SWEEP, cnt=0, ghr_q=0; pred_valid_o=0, pred_taken_o=0, pred_ghr_o=0; ready_o=0.
  - Table storage itself is not reset; the sweep initialises it.
  - ready_o rises NR_ROWS cycles after reset deasserts.

Optional Feature:
- Macro: GSHARE_BP_PERF_CNT_EN.
- Defined: adds outputs perf_lookup_o, perf_update_o and perf_mispredict_o, each 32-bit.
  - They count accepted lookups, table writes and upd_mispredict_i pulses respectively.
  - They saturate at 32'hFFFFFFFF, are cleared by reset, and are not cleared by flush.
- Undefined: these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package gshare_pkg holds:
  - entry typedef parameterised by CTR_BITS;
  - fsm state enum {IDLE, SWEEP};
  - functions sat_update(ctr, taken) and fold_ghr(ghr).
- One sub-module, gshare_bp_ram: NR_ROWS x INSTR_PER_FETCH entries; one registered read port, one write port with per-slot write enables; no reset.

Test Plan:
- Reset, then count: rst_i pulse with NR_ENTRIES=1024, INSTR_PER_FETCH=2 -> ready_o=0 for 512 cycles then 1; first lookup gives pred_valid_o=2'b00, pred_taken_o=2'b11.
- Saturation: 4 taken updates to pc 0x100 with ghr 0 -> ctr 10->11->11->11; then 3 not-taken -> 10, 01, 00; lookup gives taken=0, valid=1.
- GHR speculation and repair: 3 spec_taken=1 pulses -> ghr_q=0x007. Mispredict with upd_ghr_i=0x005, taken=0 -> ghr_q=0x00A; a same-cycle spec pulse is ignored.
- Bypass: update and lookup to the same row/slot in the same cycle, ctr 01 -> taken, next-cycle pred_taken_o=1.
- Flush mid-sweep: assert flush_bp_i at sweep cycle 100 -> cnt restarts; ready_o high 512 cycles later. Updates during the sweep are lost.
- Debug mode: debug_mode_i=1 with a taken update -> table unchanged; a mispredict in the same update still repairs ghr.

Source files
------------

// File: rtl/gshare_pkg.sv
// gshare_pkg: shared FSM state, saturating-counter update and GHR folding for gshare_bp
package gshare_pkg;
  localparam int CTR_MAX = 16;
  localparam int GHR_MAX = 64;
  localparam int RB_MAX = 32;
  typedef enum logic {IDLE, SWEEP} state_t;
  function automatic logic [CTR_MAX-1:0] sat_update(input logic [CTR_MAX-1:0] ctr, input logic taken, input int unsigned bits);
    logic [CTR_MAX-1:0] top;
    top = (CTR_MAX'(1) << bits) - CTR_MAX'(1);
    return taken ? ((ctr == top) ? ctr : ctr + CTR_MAX'(1)) : ((ctr == '0) ? ctr : ctr - CTR_MAX'(1));
  endfunction
  // XOR successive rb-bit chunks; bits beyond the real history are zero, padding the top chunk
  function automatic logic [RB_MAX-1:0] fold_ghr(input logic [GHR_MAX-1:0] ghr, input int unsigned rb);
    logic [RB_MAX-1:0] f;
    f = '0;
    for (int unsigned i = 0; i < GHR_MAX; i++) f[5'(i % rb)] ^= ghr[6'(i)];
    return f;
  endfunction
endpackage

// File: rtl/gshare_bp_ram.sv
// gshare_bp_ram: row-organised counter table, registered lookup port with write bypass, async RMW port
module gshare_bp_ram #(
  parameter int ROWS = 512,
  parameter int SLOTS = 2,
  parameter int W = 3,
  parameter int AW = 9
) (
  input  logic                  clk,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [SLOTS-1:0][W-1:0] rdata,
  input  logic [AW-1:0]         maddr,
  output logic [SLOTS-1:0][W-1:0] mdata,
  input  logic [SLOTS-1:0]      we,
  input  logic [AW-1:0]         waddr,
  input  logic [SLOTS-1:0][W-1:0] wdata
);
  logic [SLOTS-1:0][W-1:0] mem [ROWS];
  assign mdata = mem[maddr];
  always_ff @(posedge clk) begin
    for (int s = 0; s < SLOTS; s++) begin
      if (we[s]) mem[waddr][s] <= wdata[s];
      if (re) rdata[s] <= (we[s] && waddr == raddr) ? wdata[s] : mem[raddr][s];
    end
  end
endmodule

// File: rtl/gshare_bp.sv
// gshare_bp: gshare direction predictor with speculative GHR, mispredict repair and sweep flush.
// Define GSHARE_BP_PERF_CNT_EN to add saturating lookup/update/mispredict counters.
module gshare_bp import gshare_pkg::*; #(
  parameter int NR_ENTRIES = 1024,
  parameter int INSTR_PER_FETCH = 2,
  parameter int CTR_BITS = 2,
  parameter int GHR_BITS = 12,
  parameter int VLEN = 39,
  parameter int RVC = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_bp_i,
  input  logic                       debug_mode_i,
  input  logic                       vpc_valid_i,
  input  logic [VLEN-1:0]            vpc_i,
  input  logic                       spec_valid_i,
  input  logic                       spec_taken_i,
  input  logic                       upd_valid_i,
  input  logic [VLEN-1:0]            upd_pc_i,
  input  logic                       upd_taken_i,
  input  logic                       upd_mispredict_i,
  input  logic [GHR_BITS-1:0]        upd_ghr_i,
  output logic [INSTR_PER_FETCH-1:0] pred_valid_o,
  output logic [INSTR_PER_FETCH-1:0] pred_taken_o,
  output logic [GHR_BITS-1:0]        pred_ghr_o,
  output logic                       ready_o
`ifdef GSHARE_BP_PERF_CNT_EN
  ,
  output logic [31:0]                perf_lookup_o,
  output logic [31:0]                perf_update_o,
  output logic [31:0]                perf_mispredict_o
`endif
);
  localparam int NR_ROWS = NR_ENTRIES / INSTR_PER_FETCH;
  localparam int RB = $clog2(NR_ROWS);
  localparam int SB = $clog2(INSTR_PER_FETCH);
  localparam int SW = SB > 0 ? SB : 1;
  localparam int OFFSET = RVC != 0 ? 1 : 2;
  typedef struct packed {
    logic valid;
    logic [CTR_BITS-1:0] ctr;
  } entry_t;
  localparam entry_t INIT = '{valid: 1'b0, ctr: CTR_BITS'(1) << (CTR_BITS - 1)};
  state_t state;
  logic [RB-1:0] cnt, look_row, upd_row, waddr;
  logic [GHR_BITS-1:0] ghr_q, ghr_d;
  logic [SW-1:0] upd_slot;
  logic [INSTR_PER_FETCH-1:0] we;
  entry_t [INSTR_PER_FETCH-1:0] rdata, mdata, wdata;
  entry_t cur, nxt;
  logic accept, upd_en, sweep, val_q, seen_q;
  logic unused_pc;
  assign unused_pc = ^{vpc_i, upd_pc_i};
  assign ready_o = state == IDLE;
  assign sweep = state == SWEEP;
  assign accept = vpc_valid_i && ready_o;
  assign upd_en = upd_valid_i && !debug_mode_i && ready_o;
  assign look_row = RB'(vpc_i >> (OFFSET + SB)) ^ RB'(fold_ghr(GHR_MAX'(ghr_q), RB));
  assign upd_row = RB'(upd_pc_i >> (OFFSET + SB)) ^ RB'(fold_ghr(GHR_MAX'(upd_ghr_i), RB));
  assign upd_slot = (RVC != 0 && SB > 0) ? SW'(upd_pc_i >> OFFSET) : '0;
  assign cur = mdata[upd_slot];
  assign nxt = '{valid: 1'b1, ctr: CTR_BITS'(sat_update(CTR_MAX'(cur.ctr), upd_taken_i, CTR_BITS))};
  assign waddr = sweep ? cnt : upd_row;
  // Shifting through a concat keeps the low GHR_BITS, which also covers GHR_BITS=1
  assign ghr_d = (upd_valid_i && upd_mispredict_i) ? GHR_BITS'({upd_ghr_i, upd_taken_i}) :
                 spec_valid_i ? GHR_BITS'({ghr_q, spec_taken_i}) : ghr_q;
  always_comb begin
    we = '0;
    wdata = '0;
    for (int s = 0; s < INSTR_PER_FETCH; s++) begin
      we[s] = sweep || (upd_en && upd_slot == SW'(s));
      wdata[s] = sweep ? INIT : nxt;
    end
  end
  always_comb begin
    pred_valid_o = '0;
    pred_taken_o = '0;
    for (int s = 0; s < INSTR_PER_FETCH; s++) begin
      pred_valid_o[s] = val_q & rdata[s].valid;
      pred_taken_o[s] = seen_q & rdata[s].ctr[CTR_BITS-1];
    end
  end
  gshare_bp_ram #(.ROWS(NR_ROWS), .SLOTS(INSTR_PER_FETCH), .W(CTR_BITS + 1), .AW(RB)) u_ram (
    .clk(clk_i), .re(accept), .raddr(look_row), .rdata(rdata),
    .maddr(upd_row), .mdata(mdata), .we(we), .waddr(waddr), .wdata(wdata)
  );
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= SWEEP;
      cnt <= '0;
      ghr_q <= '0;
      val_q <= 1'b0;
      seen_q <= 1'b0;
      pred_ghr_o <= '0;
    end else begin
      ghr_q <= ghr_d;
      if (flush_bp_i) begin
        state <= SWEEP;
        cnt <= '0;
      end else if (sweep) begin
        cnt <= cnt + RB'(1);
        if (cnt == RB'(NR_ROWS - 1)) state <= IDLE;
      end
      if (accept) begin
        val_q <= 1'b1;
        seen_q <= 1'b1;
        pred_ghr_o <= ghr_q;
      end else if (!ready_o) val_q <= 1'b0;
    end
  end
`ifdef GSHARE_BP_PERF_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_lookup_o <= '0;
      perf_update_o <= '0;
      perf_mispredict_o <= '0;
    end else begin
      if (accept && !(&perf_lookup_o)) perf_lookup_o <= perf_lookup_o + 32'd1;
      if (upd_en && !(&perf_update_o)) perf_update_o <= perf_update_o + 32'd1;
      if (upd_valid_i && upd_mispredict_i && !(&perf_mispredict_o)) perf_mispredict_o <= perf_mispredict_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_gshare_bp.sv
// tb_gshare_bp: directed scenario tests for gshare_bp with hand-computed expectations
module tb_gshare_bp;
  logic clk = 0, rst = 0, flush = 0, dbg = 0, vv = 0, sv = 0, st = 0, uv = 0, ut = 0, um = 0;
  logic [38:0] vpc = '0, upc = '0;
  logic [11:0] ug = '0, pg;
  logic [1:0] pv, pt;
  logic rdy;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  gshare_bp dut (
    .clk_i(clk), .rst_i(rst), .flush_bp_i(flush), .debug_mode_i(dbg),
    .vpc_valid_i(vv), .vpc_i(vpc), .spec_valid_i(sv), .spec_taken_i(st),
    .upd_valid_i(uv), .upd_pc_i(upc), .upd_taken_i(ut), .upd_mispredict_i(um), .upd_ghr_i(ug),
    .pred_valid_o(pv), .pred_taken_o(pt), .pred_ghr_o(pg), .ready_o(rdy)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic lookup(input logic [38:0] pc);
    vv = 1; vpc = pc;
    tick();
    vv = 0;
  endtask
  task automatic update(input logic [38:0] pc, input logic [11:0] g, input logic t, input logic m);
    uv = 1; upc = pc; ug = g; ut = t; um = m;
    tick();
    uv = 0; um = 0;
  endtask
  task automatic test_reset();
    int n;
    tick();
    #2 rst = 1;
    #1;
    checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", rdy); end
    checks++; if (pv !== 2'b00) begin failures++; $display("FAIL reset_pv got=%b exp=00", pv); end
    checks++; if (pt !== 2'b00) begin failures++; $display("FAIL reset_pt got=%b exp=00", pt); end
    checks++; if (pg !== 12'h000) begin failures++; $display("FAIL reset_pg got=%h exp=000", pg); end
    tick();
    rst = 0;
    n = 0;
    while (rdy !== 1'b1 && n < 2000) begin tick(); n++; end
    checks++; if (n != 512) begin failures++; $display("FAIL reset_sweep_len got=%0d exp=512", n); end
    lookup(39'h100);
    checks++; if (pv !== 2'b00) begin failures++; $display("FAIL first_pv got=%b exp=00", pv); end
    checks++; if (pt !== 2'b11) begin failures++; $display("FAIL first_pt got=%b exp=11", pt); end
    checks++; if (pg !== 12'h000) begin failures++; $display("FAIL first_pg got=%h exp=000", pg); end
  endtask
  task automatic test_saturation();
    logic dirs [10] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
    logic msb [10] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 1};
    for (int i = 0; i < 10; i++) begin
      update(39'h100, 12'h000, dirs[i], 1'b0);
      lookup(39'h100);
      checks++; if (pv !== 2'b01) begin failures++; $display("FAIL sat_pv step=%0d got=%b exp=01", i, pv); end
      checks++; if (pt !== {1'b1, msb[i]}) begin failures++; $display("FAIL sat_pt step=%0d got=%b exp=%b", i, pt, {1'b1, msb[i]}); end
    end
  endtask
  task automatic test_ghr();
    sv = 1; st = 1;
    repeat (3) tick();
    sv = 0;
    lookup(39'h100);
    checks++; if (pg !== 12'h007) begin failures++; $display("FAIL ghr_spec got=%h exp=007", pg); end
    checks++; if (pv !== 2'b00) begin failures++; $display("FAIL ghr_spec_row_pv got=%b exp=00", pv); end
    sv = 1; st = 1;
    update(39'h200, 12'h005, 1'b0, 1'b1);
    sv = 0;
    lookup(39'h100);
    checks++; if (pg !== 12'h00A) begin failures++; $display("FAIL ghr_repair got=%h exp=00a", pg); end
    update(39'h100, 12'hE00, 1'b1, 1'b0);
    update(39'h600, 12'h003, 1'b1, 1'b1);
    lookup(39'h100);
    checks++; if (pg !== 12'h007) begin failures++; $display("FAIL ghr_fold_pg got=%h exp=007", pg); end
    checks++; if (pv !== 2'b01) begin failures++; $display("FAIL ghr_fold_pv got=%b exp=01", pv); end
    checks++; if (pt !== 2'b11) begin failures++; $display("FAIL ghr_fold_pt got=%b exp=11", pt); end
    update(39'h400, 12'h000, 1'b0, 1'b1);
    lookup(39'h100);
    checks++; if (pg !== 12'h000) begin failures++; $display("FAIL ghr_restore_pg got=%h exp=000", pg); end
    checks++; if (pv !== 2'b01 || pt !== 2'b11) begin failures++; $display("FAIL ghr_restore_entry got=%b/%b exp=01/11", pv, pt); end
  endtask
  task automatic test_bypass();
    update(39'h500, 12'h000, 1'b0, 1'b0);
    vv = 1; vpc = 39'h500;
    update(39'h500, 12'h000, 1'b1, 1'b0);
    vv = 0;
    checks++; if (pv !== 2'b01) begin failures++; $display("FAIL bypass_pv got=%b exp=01", pv); end
    checks++; if (pt !== 2'b11) begin failures++; $display("FAIL bypass_pt got=%b exp=11", pt); end
    lookup(39'h500);
    checks++; if (pt !== 2'b11) begin failures++; $display("FAIL bypass_stored_pt got=%b exp=11", pt); end
  endtask
  task automatic test_debug();
    dbg = 1;
    update(39'h700, 12'h001, 1'b1, 1'b1);
    dbg = 0;
    lookup(39'h708);
    checks++; if (pg !== 12'h003) begin failures++; $display("FAIL debug_ghr got=%h exp=003", pg); end
    checks++; if (pv !== 2'b00) begin failures++; $display("FAIL debug_nowrite_pv got=%b exp=00", pv); end
    update(39'h700, 12'h001, 1'b1, 1'b0);
    lookup(39'h708);
    checks++; if (pv !== 2'b01) begin failures++; $display("FAIL debug_off_write_pv got=%b exp=01", pv); end
    update(39'h400, 12'h000, 1'b0, 1'b1);
  endtask
  task automatic test_flush();
    int n;
    flush = 1;
    tick();
    flush = 0;
    checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b exp=0", rdy); end
    lookup(39'h500);
    checks++; if (pv !== 2'b00) begin failures++; $display("FAIL flush_pv got=%b exp=00", pv); end
    checks++; if (pg !== 12'h003) begin failures++; $display("FAIL flush_pg_hold got=%h exp=003", pg); end
    repeat (99) tick();
    flush = 1;
    tick();
    flush = 0;
    repeat (300) tick();
    update(39'h000, 12'h000, 1'b1, 1'b1);
    n = 301;
    while (rdy !== 1'b1 && n < 2000) begin tick(); n++; end
    checks++; if (n != 512) begin failures++; $display("FAIL flush_restart_len got=%0d exp=512", n); end
    lookup(39'h004);
    checks++; if (pg !== 12'h001) begin failures++; $display("FAIL flush_repair_pg got=%h exp=001", pg); end
    checks++; if (pv !== 2'b00 || pt !== 2'b11) begin failures++; $display("FAIL flush_dropped_upd got=%b/%b exp=00/11", pv, pt); end
  endtask
  task automatic test_back_to_back();
    update(39'h010, 12'h001, 1'b0, 1'b0);
    update(39'h010, 12'h001, 1'b0, 1'b0);
    update(39'h012, 12'h001, 1'b0, 1'b0);
    update(39'h010, 12'h001, 1'b1, 1'b0);
    lookup(39'h010);
    checks++; if (pv !== 2'b11) begin failures++; $display("FAIL b2b_pv got=%b exp=11", pv); end
    checks++; if (pt !== 2'b00) begin failures++; $display("FAIL b2b_pt got=%b exp=00", pt); end
  endtask
  task automatic test_reset_mid();
    #3 rst = 1;
    #1;
    checks++; if (rdy !== 1'b0 || pv !== 2'b00 || pt !== 2'b00 || pg !== 12'h000) begin
      failures++; $display("FAIL midreset got=%b/%b/%b/%h exp=0/00/00/000", rdy, pv, pt, pg);
    end
    tick();
    rst = 0;
  endtask
  initial begin
    test_reset();
    test_saturation();
    test_ghr();
    test_bypass();
    test_debug();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
